// File: rtl/systolic_operand_loader.sv
// Serial operand loader for the systolic multiplier: assembles NxN matrices A and B
// from a valid/ready stream, then releases the multiplier for a fixed compute window.
module systolic_operand_loader #(
  parameter int N           = 2,
  parameter int OP_WIDTH    = 8,
  parameter int HOLD_CYCLES = 3 * N
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OP_WIDTH-1:0]       in_data,
  input  logic                      abort,
  output logic [N*N*OP_WIDTH-1:0]   a,
  output logic [N*N*OP_WIDTH-1:0]   b,
  output logic                      mult_reset,
  output logic                      busy,
  output logic                      done
);

  localparam int NN    = N * N;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_s;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          idx_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [CNT_W-1:0]          cnt_s;
  logic                      accept_s;
  logic                      write_a_s;
  logic                      write_b_s;
  logic [N*N*OP_WIDTH-1:0]   a_r;
  logic [N*N*OP_WIDTH-1:0]   b_r;
  logic                      mult_reset_r;
  logic                      busy_r;
  logic                      done_r;

  // Ready decode: only the two load states take operands.
  always_comb begin
    in_ready = 1'b0;
    if ((state_r == LOAD_A) || (state_r == LOAD_B)) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s = in_valid & in_ready & ~abort;

  // Next-state, index/counter update and slot write enables.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    write_a_s = 1'b0;
    write_b_s = 1'b0;
    case (state_r)
      LOAD_A: begin
        if (abort) begin
          idx_s   = IDX_ZERO;
          state_s = LOAD_A;
        end else if (accept_s) begin
          write_a_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = LOAD_B;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          state_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (abort) begin
          idx_s   = IDX_ZERO;
          state_s = LOAD_A;
        end else if (accept_s) begin
          write_b_s = 1'b1;
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            cnt_s   = CNT_ZERO;
            state_s = COMPUTE;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          state_s = LOAD_B;
        end
      end
      COMPUTE: begin
        if (abort) begin
          cnt_s   = CNT_ZERO;
          state_s = LOAD_A;
        end else if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_s = LOAD_A;
      end
      default: begin
        state_s = LOAD_A;
        idx_s   = IDX_ZERO;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Control state, counters and registered handshake outputs; outputs follow the
  // next state so mult_reset drops on the very edge that accepts the last B element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= LOAD_A;
      idx_r        <= IDX_ZERO;
      cnt_r        <= CNT_ZERO;
      mult_reset_r <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_r        <= cnt_s;
      mult_reset_r <= (state_s != COMPUTE);
      busy_r       <= (state_s == COMPUTE);
      done_r       <= (state_s == DONE);
    end
  end

  // Operand storage; slots are only ever overwritten, never cleared outside reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r <= '0;
      b_r <= '0;
    end else begin
      if (write_a_s) begin
        a_r[OP_WIDTH*idx_r +: OP_WIDTH] <= in_data;
      end else begin
        a_r <= a_r;
      end
      if (write_b_s) begin
        b_r[OP_WIDTH*idx_r +: OP_WIDTH] <= in_data;
      end else begin
        b_r <= b_r;
      end
    end
  end

  assign a          = a_r;
  assign b          = b_r;
  assign mult_reset = mult_reset_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_systolic_operand_loader.sv
// Directed bench for systolic_operand_loader (N=2, OP_WIDTH=8, HOLD_CYCLES=6) with a
// scoreboard of expected {a,b} pushed at load time and popped on each done pulse.
module tb_systolic_operand_loader;

  localparam int N = 2;
  localparam int W = 8;
  localparam int H = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            abort = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            in_ready;
  logic [N*N*W-1:0] a;
  logic [N*N*W-1:0] b;
  logic            mult_reset;
  logic            busy;
  logic            done;

  int pass_cnt = 0;
  int check_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1000;
  int done_gap = 0;
  int d0;
  logic [63:0] sb_q[$];

  systolic_operand_loader #(.N(N), .OP_WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .a(a), .b(b),
    .mult_reset(mult_reset), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_gap      = cyc - last_done_cyc;
      last_done_cyc = cyc;
      done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Offer one operand after 'gap' idle cycles; called and returns at posedge+1.
  task automatic send(input logic [W-1:0] d, input int gap);
    logic rdy;
    logic ok;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    in_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic load(input logic [W-1:0] base, input bit same, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      send(same ? base : base + W'(i), gaps ? int'($urandom_range(1, 3)) : 0);
    end
  endtask

  // Check the full compute window, done pulse and return to loading.
  task automatic run_compute(input bit hold_valid);
    logic [63:0] e;
    if (hold_valid) begin in_valid = 1'b1; in_data = 8'hEE; end
    for (int i = 0; i < H; i++) begin
      @(negedge clk);
      check("cmp_mult_reset", 64'(mult_reset), 64'd0);
      check("cmp_busy", 64'(busy), 64'd1);
      check("cmp_in_ready", 64'(in_ready), 64'd0);
      check("cmp_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd1);
    check("done_mult_reset", 64'(mult_reset), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    check("sb_entry", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_a", 64'(a), 64'(e[63:32]));
      check("sb_b", 64'(b), 64'(e[31:0]));
    end
    @(negedge clk);
    check("post_done", 64'(done), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_mult_reset", 64'(mult_reset), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", 64'(a), 64'd0);
    check("rst_b", 64'(b), 64'd0);
    check("rst_mult_reset", 64'(mult_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic back-to-back load.
    sb_q.push_back({32'h04030201, 32'h08070605});
    load(8'h01, 1'b0, 1'b0);
    run_compute(1'b0);

    // Gaps between elements, in_valid held high across compute.
    sb_q.push_back({32'h04030201, 32'h08070605});
    load(8'h01, 1'b0, 1'b1);
    run_compute(1'b1);

    // Abort mid-load drops element 9 and restarts at slot 0.
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    in_valid = 1'b1; in_data = 8'h09; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_load_in_ready", 64'(in_ready), 64'd1);
    check("abort_load_mult_reset", 64'(mult_reset), 64'd1);
    sb_q.push_back({32'h0D0C0B0A, 32'h11100F0E});
    load(8'h0A, 1'b0, 1'b0);
    run_compute(1'b0);

    // Abort on compute cycle 3.
    load(8'h14, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_cmp_pre", 64'(mult_reset), 64'd0);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_cmp_cycle3", 64'(busy), 64'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    check("abort_cmp_mult_reset", 64'(mult_reset), 64'd1);
    check("abort_cmp_busy", 64'(busy), 64'd0);
    check("abort_cmp_in_ready", 64'(in_ready), 64'd1);
    check("abort_cmp_done", 64'(done), 64'd0);
    check("abort_cmp_a", 64'(a), 64'h17161514);
    check("abort_cmp_b", 64'(b), 64'h1B1A1918);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    check("abort_cmp_no_done", 64'(done_cnt - d0), 64'd0);

    // Asynchronous reset in the middle of compute.
    load(8'h1E, 1'b0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_rst_a", 64'(a), 64'd0);
    check("async_rst_b", 64'(b), 64'd0);
    check("async_rst_mult_reset", 64'(mult_reset), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back({32'h04030201, 32'h08070605});
    load(8'h01, 1'b0, 1'b0);
    run_compute(1'b0);

    // Two consecutive jobs.
    @(posedge clk); #1;
    d0 = done_cnt;
    sb_q.push_back({32'h44434241, 32'h48474645});
    load(8'h41, 1'b0, 1'b0);
    run_compute(1'b0);
    sb_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFF});
    load(8'hFF, 1'b1, 1'b0);
    run_compute(1'b0);
    check("b2b_done_count", 64'(done_cnt - d0), 64'd2);
    check("b2b_done_gap", 64'(done_gap >= 15), 64'd1);
    check("b2b_a", 64'(a), 64'hFFFFFFFF);
    check("b2b_b", 64'(b), 64'hFFFFFFFF);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
